// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared state encoding and address-split widths for the instruction cache
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } state_e;

  localparam int LINE_WORDS_DEF = 4;
  localparam int NUM_LINES_DEF  = 64;

  function automatic int calc_offset_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int calc_index_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  // Word addresses are 30 bits wide; whatever offset and index leave is tag.
  function automatic int calc_tag_w(input int line_words, input int num_lines);
    return 30 - $clog2(line_words) - $clog2(num_lines);
  endfunction

  localparam int OFFSET_W = calc_offset_w(LINE_WORDS_DEF);
  localparam int INDEX_W  = calc_index_w(NUM_LINES_DEF);
  localparam int TAG_W    = calc_tag_w(LINE_WORDS_DEF, NUM_LINES_DEF);

endpackage

// File: rtl/instruction_cache_if.sv
// rtl/instruction_cache_if.sv - fetch-side and refill-side signals of the instruction cache
interface instruction_cache_if;

  logic [31:2] cache_address_i;
  logic [31:2] cache_data_o;
  logic        cache_blocking_n_o;
  logic        flush_i;
  logic        mem_req_o;
  logic [31:2] mem_addr_o;
  logic        mem_ready_i;
  logic        mem_valid_i;
  logic [31:0] mem_data_i;

  modport slave (
    input  cache_address_i, flush_i, mem_ready_i, mem_valid_i, mem_data_i,
    output cache_data_o, cache_blocking_n_o, mem_req_o, mem_addr_o
  );

  modport master (
    output cache_address_i, flush_i, mem_ready_i, mem_valid_i, mem_data_i,
    input  cache_data_o, cache_blocking_n_o, mem_req_o, mem_addr_o
  );

endinterface

// File: rtl/increment.sv
// rtl/increment.sv - plain +1 incrementer with carry out
module increment #(
  parameter int DATA_WIDTH = 2
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  carry_o
);

  assign {carry_o, data_o} = {1'b0, data_i} + {{DATA_WIDTH{1'b0}}, 1'b1};

endmodule

// File: rtl/instruction_cache.sv
// rtl/instruction_cache.sv - direct-mapped read-only instruction cache with whole-line refill
module instruction_cache
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int NUM_LINES  = NUM_LINES_DEF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  instruction_cache_if.slave  bus
);

  localparam int OFF_W = calc_offset_w(LINE_WORDS);
  localparam int IDX_W = calc_index_w(NUM_LINES);
  localparam int TG_W  = calc_tag_w(LINE_WORDS, NUM_LINES);

  state_e                    state_q, state_d;
  logic [NUM_LINES-1:0]      valid_q, valid_d;
  logic                      kill_q, kill_d;
  logic [TG_W+IDX_W-1:0]     line_q, line_d;
  logic [OFF_W-1:0]          beat_q, beat_d;
  logic [OFF_W-1:0]          beat_inc;
  logic                      last_beat;
  logic                      fill_we;

  logic [TG_W-1:0]           tag_mem  [NUM_LINES];
  logic [29:0]               data_mem [NUM_LINES*LINE_WORDS];

  logic [OFF_W-1:0]          addr_off;
  logic [IDX_W-1:0]          addr_idx;
  logic [TG_W-1:0]           addr_tag;
  logic [IDX_W-1:0]          fill_idx;
  logic [TG_W-1:0]           fill_tag;
  logic                      hit;

  assign addr_off = bus.cache_address_i[2 +: OFF_W];
  assign addr_idx = bus.cache_address_i[2+OFF_W +: IDX_W];
  assign addr_tag = bus.cache_address_i[31 -: TG_W];
  assign fill_idx = line_q[IDX_W-1:0];
  assign fill_tag = line_q[IDX_W +: TG_W];

  assign hit = valid_q[addr_idx] && (tag_mem[addr_idx] == addr_tag);

  assign bus.cache_data_o       = data_mem[{addr_idx, addr_off}];
  assign bus.cache_blocking_n_o = hit && (state_q == IDLE) && !bus.flush_i;
  assign bus.mem_req_o          = (state_q == REQ);
  assign bus.mem_addr_o         = {line_q, {OFF_W{1'b0}}};

  // Beat counter wraps to zero on the last beat, so its carry marks the final word.
  increment #(.DATA_WIDTH(OFF_W)) u_beat_inc (
    .data_i  (beat_q),
    .data_o  (beat_inc),
    .carry_o (last_beat)
  );

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    kill_d  = kill_q;
    line_d  = line_q;
    beat_d  = beat_q;
    fill_we = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.flush_i) begin
          valid_d = '0;
        end else if (!hit) begin
          state_d = REQ;
          line_d  = {addr_tag, addr_idx};
        end
      end
      REQ: begin
        if (bus.flush_i) valid_d = '0;
        if (bus.mem_ready_i) begin
          state_d = FILL;
          beat_d  = '0;
        end
      end
      FILL: begin
        if (bus.flush_i) begin
          valid_d = '0;
          kill_d  = 1'b1;
        end
        if (bus.mem_valid_i) begin
          fill_we = 1'b1;
          beat_d  = beat_inc;
          if (last_beat) begin
            // A flush landing on the final beat also keeps the line invalid.
            if (!kill_q && !bus.flush_i) valid_d[fill_idx] = 1'b1;
            kill_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      valid_q <= '0;
      kill_q  <= 1'b0;
      line_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      kill_q  <= kill_d;
      line_q  <= line_d;
      beat_q  <= beat_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_we) begin
      data_mem[{fill_idx, beat_q}] <= bus.mem_data_i[31:2];
      if (last_beat) tag_mem[fill_idx] <= fill_tag;
    end
  end

endmodule

// File: tb/tb_instruction_cache.sv
// tb/tb_instruction_cache.sv - directed self-checking bench for instruction_cache
module tb_instruction_cache;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  instruction_cache_if bus ();

  instruction_cache #(.LINE_WORDS(4), .NUM_LINES(64)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic hit_now(input string tag, input logic [31:0] word);
    check({tag, "_blk"}, {31'b0, bus.cache_blocking_n_o}, 32'd1);
    check({tag, "_data"}, {bus.cache_data_o, 2'b11}, word);
    check({tag, "_noreq"}, {31'b0, bus.mem_req_o}, 32'd0);
  endtask

  task automatic expect_hit(input logic [29:0] a, input logic [31:0] word);
    @(posedge clk); #1;
    bus.cache_address_i = a;
    @(negedge clk);
    hit_now("hit", word);
  endtask

  task automatic expect_miss(input logic [29:0] a);
    @(posedge clk); #1;
    bus.cache_address_i = a;
    @(negedge clk);
    check("miss_blk", {31'b0, bus.cache_blocking_n_o}, 32'd0);
    check("miss_noreq_yet", {31'b0, bus.mem_req_o}, 32'd0);
  endtask

  // Called in the cycle a miss is visible; serves the request and all four beats.
  task automatic serve(input logic [29:0] exp_addr,
                       input logic [31:0] b0, input logic [31:0] b1,
                       input logic [31:0] b2, input logic [31:0] b3,
                       input int ready_wait, input int gap,
                       input int redir_beat, input logic [29:0] redir_addr,
                       input int flush_beat);
    logic [31:0] beats [4];
    beats = '{b0, b1, b2, b3};
    for (int c = 0; c <= ready_wait; c++) begin
      @(posedge clk); #1;
      bus.mem_valid_i = 1'b0;
      bus.mem_ready_i = (c == ready_wait);
      @(negedge clk);
      check("req", {31'b0, bus.mem_req_o}, 32'd1);
      check("req_addr", {2'b0, bus.mem_addr_o}, {2'b0, exp_addr});
    end
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < ((b == 0) ? 0 : gap); g++) begin
        @(posedge clk); #1;
        bus.mem_ready_i = 1'b0;
        bus.mem_valid_i = 1'b0;
        bus.flush_i     = 1'b0;
        @(negedge clk);
        check("gap_noreq", {31'b0, bus.mem_req_o}, 32'd0);
      end
      @(posedge clk); #1;
      bus.mem_ready_i = 1'b0;
      bus.mem_valid_i = 1'b1;
      bus.mem_data_i  = beats[b];
      bus.flush_i     = (b == flush_beat);
      if (b == redir_beat) bus.cache_address_i = redir_addr;
      @(negedge clk);
      check("fill_blk", {31'b0, bus.cache_blocking_n_o}, 32'd0);
      check("fill_noreq", {31'b0, bus.mem_req_o}, 32'd0);
    end
    @(posedge clk); #1;
    bus.mem_valid_i = 1'b0;
    bus.flush_i     = 1'b0;
    bus.mem_data_i  = '0;
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.cache_address_i = '0;
    bus.flush_i     = 1'b0;
    bus.mem_ready_i = 1'b0;
    bus.mem_valid_i = 1'b0;
    bus.mem_data_i  = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_blk", {31'b0, bus.cache_blocking_n_o}, 32'd0);
    check("rst_req", {31'b0, bus.mem_req_o}, 32'd0);
    check("rst_addr", {2'b0, bus.mem_addr_o}, 32'd0);

    // Cold miss at address 0 with immediate ready
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("cold_blk", {31'b0, bus.cache_blocking_n_o}, 32'd0);
    check("cold_noreq", {31'b0, bus.mem_req_o}, 32'd0);
    serve(30'h0, 32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193, 0, 0, -1, 30'h0, -1);
    hit_now("cold_w0", 32'h00000013);
    expect_hit(30'h1, 32'h00100093);
    expect_hit(30'h2, 32'h00200113);
    expect_hit(30'h3, 32'h00300193);

    // Conflict: word 0x100 shares index 0 with a different tag
    expect_miss(30'h100);
    serve(30'h100, 32'h00400213, 32'h00500293, 32'h00600313, 32'h00700393, 0, 0, -1, 30'h0, -1);
    hit_now("conf_w0", 32'h00400213);
    expect_hit(30'h103, 32'h00700393);
    expect_miss(30'h0);

    // Delayed handshake refilling address 0: ready late, beats with gaps
    serve(30'h0, 32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193, 3, 1, -1, 30'h0, -1);
    hit_now("dly_w0", 32'h00000013);
    expect_hit(30'h1, 32'h00100093);
    expect_hit(30'h2, 32'h00200113);
    expect_hit(30'h3, 32'h00300193);

    // Redirect to 0x40 during the fill of line 0x8
    expect_miss(30'h8);
    serve(30'h8, 32'h00a00513, 32'h00b00593, 32'h00c00613, 32'h00d00693, 0, 0, 1, 30'h40, -1);
    check("redir_miss", {31'b0, bus.cache_blocking_n_o}, 32'd0);
    serve(30'h40, 32'h01000813, 32'h01100893, 32'h01200913, 32'h01300993, 0, 0, -1, 30'h0, -1);
    hit_now("redir_w40", 32'h01000813);
    expect_hit(30'h8, 32'h00a00513);
    expect_hit(30'hb, 32'h00d00693);

    // Flush during fill: line stays invalid, everything else is dropped too
    expect_miss(30'h80);
    serve(30'h80, 32'h02000a13, 32'h02100a93, 32'h02200b13, 32'h02300b93, 0, 0, -1, 30'h0, 1);
    check("kill_blk", {31'b0, bus.cache_blocking_n_o}, 32'd0);
    serve(30'h80, 32'h02000a13, 32'h02100a93, 32'h02200b13, 32'h02300b93, 0, 0, -1, 30'h0, -1);
    hit_now("refill_w80", 32'h02000a13);
    expect_miss(30'h8);
    serve(30'h8, 32'h00a00513, 32'h00b00593, 32'h00c00613, 32'h00d00693, 0, 0, -1, 30'h0, -1);
    hit_now("refill_w8", 32'h00a00513);

    // Flush in IDLE drops blocking_n at once and suppresses the request
    @(posedge clk); #1;
    bus.flush_i = 1'b1;
    @(negedge clk);
    check("iflush_blk", {31'b0, bus.cache_blocking_n_o}, 32'd0);
    check("iflush_req", {31'b0, bus.mem_req_o}, 32'd0);
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    @(negedge clk);
    check("iflush_noreq", {31'b0, bus.mem_req_o}, 32'd0);
    check("iflush_miss", {31'b0, bus.cache_blocking_n_o}, 32'd0);
    serve(30'h8, 32'h00a00513, 32'h00b00593, 32'h00c00613, 32'h00d00693, 0, 0, -1, 30'h0, -1);
    hit_now("iflush_w8", 32'h00a00513);

    // Reset after two beats; stale beats afterwards must not land
    expect_miss(30'hc0);
    @(posedge clk); #1;
    bus.mem_ready_i = 1'b1;
    @(negedge clk);
    check("rmf_req", {31'b0, bus.mem_req_o}, 32'd1);
    for (int b = 0; b < 2; b++) begin
      @(posedge clk); #1;
      bus.mem_ready_i = 1'b0;
      bus.mem_valid_i = 1'b1;
      bus.mem_data_i  = 32'h03000c13;
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.mem_data_i = 32'hdeadbeef;
    #1;
    check("rmf_req_now", {31'b0, bus.mem_req_o}, 32'd0);
    check("rmf_blk_now", {31'b0, bus.cache_blocking_n_o}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rmf_idle_req", {31'b0, bus.mem_req_o}, 32'd0);
    check("rmf_idle_blk", {31'b0, bus.cache_blocking_n_o}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rmf_rereq", {31'b0, bus.mem_req_o}, 32'd1);
    serve(30'hc0, 32'h03000c13, 32'h03100c93, 32'h03200d13, 32'h03300d93, 0, 0, -1, 30'h0, -1);
    hit_now("rmf_w0", 32'h03000c13);
    expect_hit(30'hc1, 32'h03100c93);
    expect_hit(30'hc3, 32'h03300d93);
    expect_miss(30'h8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
